// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control definitions for the LEGv8 core: zero register index,
// hazard FSM state encoding and the default performance-counter width.
package cpu_pipe_pkg;

   localparam logic [4:0] XZR      = 5'd31;
   localparam int         HZ_CNT_W = 32;

   typedef enum logic [1:0] {
      RUN          = 2'd0,
      FREEZE       = 2'd1,
      FREEZE_FLUSH = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline datapath and the hazard unit: register/control
// observations from ID, EX and MEM in, pipeline enables and counters out.
interface hazard_unit_if import cpu_pipe_pkg::*; #(parameter int CNT_W = HZ_CNT_W);

   logic [4:0]       id_rn;
   logic [4:0]       id_rm;
   logic             id_uses_rn;
   logic             id_uses_rm;
   logic             id_is_cbz;
   logic             id_is_bcond;
   logic [4:0]       id_ex_rd;
   logic             id_ex_regwrite;
   logic             id_ex_memread;
   logic             id_ex_setflags;
   logic [4:0]       ex_mem_rd;
   logic             ex_mem_memread;
   logic             branch_taken;
   logic             mem_busy;

   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic             pipe_freeze;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic [1:0]       hz_state;

   modport master (
      output id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_cbz, id_is_bcond,
             id_ex_rd, id_ex_regwrite, id_ex_memread, id_ex_setflags,
             ex_mem_rd, ex_mem_memread, branch_taken, mem_busy,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
             stall_count, flush_count, hz_state
   );

   modport slave (
      input  id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_cbz, id_is_bcond,
             id_ex_rd, id_ex_regwrite, id_ex_memread, id_ex_setflags,
             ex_mem_rd, ex_mem_memread, branch_taken, mem_busy,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
             stall_count, flush_count, hz_state
   );

endinterface

// File: rtl/hazard_detect.sv
// Combinational data-hazard comparator: flags the ID instruction whenever an
// operand it needs cannot be forwarded in time.
module hazard_detect
   import cpu_pipe_pkg::*;
(
   input  logic [4:0] id_rn,
   input  logic [4:0] id_rm,
   input  logic       id_uses_rn,
   input  logic       id_uses_rm,
   input  logic       id_is_cbz,
   input  logic       id_is_bcond,
   input  logic [4:0] id_ex_rd,
   input  logic       id_ex_regwrite,
   input  logic       id_ex_memread,
   input  logic       id_ex_setflags,
   input  logic [4:0] ex_mem_rd,
   input  logic       ex_mem_memread,
   output logic       stall
);

   logic load_use;
   logic cbz_ex;
   logic cbz_mem;
   logic flag_dep;

   assign load_use = id_ex_memread && (id_ex_rd != XZR) &&
                     ((id_uses_rn && (id_ex_rd == id_rn)) ||
                      (id_uses_rm && (id_ex_rd == id_rm)));

   // CBZ resolves in ID, so even an ALU result in EX is too late to forward.
   assign cbz_ex   = id_is_cbz && id_ex_regwrite && (id_ex_rd != XZR) &&
                     (id_ex_rd == id_rm);

   assign cbz_mem  = id_is_cbz && ex_mem_memread && (ex_mem_rd != XZR) &&
                     (ex_mem_rd == id_rm);

   assign flag_dep = id_is_bcond && id_ex_setflags;

   assign stall = load_use || cbz_ex || cbz_mem || flag_dep;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage LEGv8 pipeline: bubbles on data
// hazards, flushes taken branches, freezes on data-memory wait.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// RUN          | normal operation, hazards evaluated every cycle
// FREEZE       | data memory busy, no branch flush owed on release
// FREEZE_FLUSH | data memory busy, taken branch arrived, flush on release
module hazard_unit
   import cpu_pipe_pkg::*;
#(
   parameter int CNT_W = HZ_CNT_W
)
(
   input  logic        clk,
   input  logic        reset,
   hazard_unit_if.slave hz
);

   localparam logic [1:0] S_RUN          = RUN;
   localparam logic [1:0] S_FREEZE       = FREEZE;
   localparam logic [1:0] S_FREEZE_FLUSH = FREEZE_FLUSH;

   logic [1:0]       state_q;
   logic [1:0]       next_state;
   logic             stall;
   logic             stall_inc;
   logic             flush_inc;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic             pipe_freeze;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   hazard_detect u_detect (
      .id_rn          (hz.id_rn),
      .id_rm          (hz.id_rm),
      .id_uses_rn     (hz.id_uses_rn),
      .id_uses_rm     (hz.id_uses_rm),
      .id_is_cbz      (hz.id_is_cbz),
      .id_is_bcond    (hz.id_is_bcond),
      .id_ex_rd       (hz.id_ex_rd),
      .id_ex_regwrite (hz.id_ex_regwrite),
      .id_ex_memread  (hz.id_ex_memread),
      .id_ex_setflags (hz.id_ex_setflags),
      .ex_mem_rd      (hz.ex_mem_rd),
      .ex_mem_memread (hz.ex_mem_memread),
      .stall          (stall)
   );

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      next_state   = state_q;

      case (state_q)
         S_RUN, S_FREEZE: begin
            if (hz.mem_busy) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               pipe_freeze = 1'b1;
               // A branch seen while already frozen is ignored; only RUN can arm a deferred flush.
               if ((state_q == S_RUN) && hz.branch_taken && !stall)
                  next_state = S_FREEZE_FLUSH;
               else
                  next_state = S_FREEZE;
            end else begin
               next_state = S_RUN;
               if (stall) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  stall_inc    = 1'b1;
               end else if (hz.branch_taken) begin
                  if_id_flush = 1'b1;
                  flush_inc   = 1'b1;
               end
            end
         end
         S_FREEZE_FLUSH: begin
            if (hz.mem_busy) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               pipe_freeze = 1'b1;
            end else begin
               if_id_flush = 1'b1;
               flush_inc   = 1'b1;
               next_state  = S_RUN;
            end
         end
         default: next_state = S_RUN;
      endcase

      if (reset) begin
         pc_write     = 1'b1;
         if_id_write  = 1'b1;
         if_id_flush  = 1'b0;
         id_ex_bubble = 1'b0;
         pipe_freeze  = 1'b0;
         stall_inc    = 1'b0;
         flush_inc    = 1'b0;
         next_state   = S_RUN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= S_RUN;
      else
         state_q <= next_state;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_inc && !(&stall_q))
            stall_q <= stall_q + CNT_W'(1);
         if (flush_inc && !(&flush_q))
            flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign hz.pc_write     = pc_write;
   assign hz.if_id_write  = if_id_write;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.id_ex_bubble = id_ex_bubble;
   assign hz.pipe_freeze  = pipe_freeze;
   assign hz.stall_count  = stall_q;
   assign hz.flush_count  = flush_q;
   assign hz.hz_state     = state_q;

endmodule
